// File: rtl/histogram_peak_locator_if.sv
// Bin read bus between the peak locator (master) and the histogram store (slave).
// The master issues bin indices; the slave returns per-axis counts with independent valids.
interface histogram_peak_locator_if #(
    parameter int IDX_W   = 8,
    parameter int COUNT_W = 9
);
    logic               readHistogram;
    logic [IDX_W-1:0]   histIndex;
    logic [COUNT_W-1:0] xHistogramOut;
    logic [COUNT_W-1:0] yHistogramOut;
    logic               xValid;
    logic               yValid;

    modport master (
        output readHistogram,
        output histIndex,
        input  xHistogramOut,
        input  yHistogramOut,
        input  xValid,
        input  yValid
    );

    modport slave (
        input  readHistogram,
        input  histIndex,
        output xHistogramOut,
        output yHistogramOut,
        output xValid,
        output yValid
    );
endinterface

// File: rtl/histogram_peak_locator.sv
// Scans the X/Y projection histograms once per start and reports, per axis, the peak bin,
// its count, the first/last occupied bin, plus the total pixel count and an object-found flag.
module histogram_peak_locator #(
    parameter int BINS    = 256,
    parameter int IDX_W   = 8,
    parameter int COUNT_W = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [COUNT_W-1:0]       binThreshold,
    histogram_peak_locator_if.master hist,
    output logic                     busy,
    output logic                     done,
    output logic [IDX_W-1:0]         xPeak,
    output logic [IDX_W-1:0]         yPeak,
    output logic [COUNT_W-1:0]       xPeakCount,
    output logic [COUNT_W-1:0]       yPeakCount,
    output logic [IDX_W-1:0]         xMin,
    output logic [IDX_W-1:0]         xMax,
    output logic [IDX_W-1:0]         yMin,
    output logic [IDX_W-1:0]         yMax,
    output logic [IDX_W+COUNT_W-1:0] pixelTotal,
    output logic                     objectFound
);

    localparam int CNT_W = IDX_W + 1;
    localparam int SUM_W = IDX_W + COUNT_W;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BINS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BINS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic is_occupied(input logic [COUNT_W-1:0] count,
                                         input logic [COUNT_W-1:0] thr);
        return count > thr;
    endfunction

    state_t             state_q, state_d;
    logic               read_q, read_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [COUNT_W-1:0] thr_q, thr_d;
    logic [CNT_W-1:0]   x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
    logic [IDX_W-1:0]   x_peak_q, x_peak_d, y_peak_q, y_peak_d;
    logic [COUNT_W-1:0] x_peak_cnt_q, x_peak_cnt_d, y_peak_cnt_q, y_peak_cnt_d;
    logic [IDX_W-1:0]   x_min_q, x_min_d, x_max_q, x_max_d;
    logic [IDX_W-1:0]   y_min_q, y_min_d, y_max_q, y_max_d;
    logic               x_found_q, x_found_d, y_found_q, y_found_d;
    logic [SUM_W-1:0]   pix_q, pix_d;
    logic               obj_q, obj_d;

    logic               x_take_s, y_take_s, x_occ_s, y_occ_s;
    logic [IDX_W-1:0]   x_idx_s, y_idx_s;

    // Next-state, per-axis result accumulation and scan control.
    always_comb begin
        state_d      = state_q;
        read_d       = read_q;
        index_d      = index_q;
        busy_d       = busy_q;
        done_d       = done_q;
        thr_d        = thr_q;
        obj_d        = obj_q;

        // Valids only count while a scan is in flight and until a full axis has returned.
        x_take_s = (state_q == ST_ISSUE || state_q == ST_DRAIN) && hist.xValid && (x_cnt_q != CNT_FULL);
        y_take_s = (state_q == ST_ISSUE || state_q == ST_DRAIN) && hist.yValid && (y_cnt_q != CNT_FULL);
        x_idx_s  = x_cnt_q[IDX_W-1:0];
        y_idx_s  = y_cnt_q[IDX_W-1:0];
        x_occ_s  = x_take_s && is_occupied(hist.xHistogramOut, thr_q);
        y_occ_s  = y_take_s && is_occupied(hist.yHistogramOut, thr_q);

        x_cnt_d      = x_take_s ? (x_cnt_q + CNT_ONE) : x_cnt_q;
        y_cnt_d      = y_take_s ? (y_cnt_q + CNT_ONE) : y_cnt_q;
        x_peak_d     = (x_take_s && (hist.xHistogramOut > x_peak_cnt_q)) ? x_idx_s : x_peak_q;
        x_peak_cnt_d = (x_take_s && (hist.xHistogramOut > x_peak_cnt_q)) ? hist.xHistogramOut : x_peak_cnt_q;
        y_peak_d     = (y_take_s && (hist.yHistogramOut > y_peak_cnt_q)) ? y_idx_s : y_peak_q;
        y_peak_cnt_d = (y_take_s && (hist.yHistogramOut > y_peak_cnt_q)) ? hist.yHistogramOut : y_peak_cnt_q;
        x_min_d      = (x_occ_s && !x_found_q) ? x_idx_s : x_min_q;
        y_min_d      = (y_occ_s && !y_found_q) ? y_idx_s : y_min_q;
        x_max_d      = x_occ_s ? x_idx_s : x_max_q;
        y_max_d      = y_occ_s ? y_idx_s : y_max_q;
        x_found_d    = x_found_q | x_occ_s;
        y_found_d    = y_found_q | y_occ_s;
        pix_d        = x_take_s ? (pix_q + {{IDX_W{1'b0}}, hist.xHistogramOut}) : pix_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_ISSUE;
                    read_d       = 1'b1;
                    index_d      = '0;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    thr_d        = binThreshold;
                    obj_d        = 1'b0;
                    x_cnt_d      = '0;
                    y_cnt_d      = '0;
                    x_peak_d     = '0;
                    y_peak_d     = '0;
                    x_peak_cnt_d = '0;
                    y_peak_cnt_d = '0;
                    x_min_d      = '0;
                    x_max_d      = '0;
                    y_min_d      = '0;
                    y_max_d      = '0;
                    x_found_d    = 1'b0;
                    y_found_d    = 1'b0;
                    pix_d        = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (index_q == IDX_LAST) begin
                    read_d  = 1'b0;
                    state_d = ST_DRAIN;
                end else begin
                    index_d = index_q + IDX_ONE;
                end
            end
            ST_DRAIN: begin
                // Look at the post-update counters so done lands right after the last valid.
                if ((x_cnt_d == CNT_FULL) && (y_cnt_d == CNT_FULL)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    obj_d   = x_found_d & y_found_d;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                done_d  = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                read_d  = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State and result registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            read_q       <= 1'b0;
            index_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            thr_q        <= '0;
            x_cnt_q      <= '0;
            y_cnt_q      <= '0;
            x_peak_q     <= '0;
            y_peak_q     <= '0;
            x_peak_cnt_q <= '0;
            y_peak_cnt_q <= '0;
            x_min_q      <= '0;
            x_max_q      <= '0;
            y_min_q      <= '0;
            y_max_q      <= '0;
            x_found_q    <= 1'b0;
            y_found_q    <= 1'b0;
            pix_q        <= '0;
            obj_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            read_q       <= read_d;
            index_q      <= index_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            thr_q        <= thr_d;
            x_cnt_q      <= x_cnt_d;
            y_cnt_q      <= y_cnt_d;
            x_peak_q     <= x_peak_d;
            y_peak_q     <= y_peak_d;
            x_peak_cnt_q <= x_peak_cnt_d;
            y_peak_cnt_q <= y_peak_cnt_d;
            x_min_q      <= x_min_d;
            x_max_q      <= x_max_d;
            y_min_q      <= y_min_d;
            y_max_q      <= y_max_d;
            x_found_q    <= x_found_d;
            y_found_q    <= y_found_d;
            pix_q        <= pix_d;
            obj_q        <= obj_d;
        end
    end

    assign hist.readHistogram = read_q;
    assign hist.histIndex     = index_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign xPeak              = x_peak_q;
    assign yPeak              = y_peak_q;
    assign xPeakCount         = x_peak_cnt_q;
    assign yPeakCount         = y_peak_cnt_q;
    assign xMin               = x_min_q;
    assign xMax               = x_max_q;
    assign yMin               = y_min_q;
    assign yMax               = y_max_q;
    assign pixelTotal         = pix_q;
    assign objectFound        = obj_q;

endmodule

// File: tb/tb_histogram_peak_locator.sv
// Randomized self-checking bench: a latency-configurable histogram store answers bin reads,
// and each scan's results are compared with a whole-array reference computation.
module tb_histogram_peak_locator;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [8:0]  binThreshold;
    logic        busy, done, objectFound;
    logic [7:0]  xPeak, yPeak, xMin, xMax, yMin, yMax;
    logic [8:0]  xPeakCount, yPeakCount;
    logic [16:0] pixelTotal;

    histogram_peak_locator_if #(.IDX_W(8), .COUNT_W(9)) hist ();

    histogram_peak_locator #(.BINS(256), .IDX_W(8), .COUNT_W(9)) dut (
        .clk(clk), .reset(reset), .start(start), .binThreshold(binThreshold), .hist(hist),
        .busy(busy), .done(done), .xPeak(xPeak), .yPeak(yPeak),
        .xPeakCount(xPeakCount), .yPeakCount(yPeakCount),
        .xMin(xMin), .xMax(xMax), .yMin(yMin), .yMax(yMax),
        .pixelTotal(pixelTotal), .objectFound(objectFound)
    );

    always #5 clk = ~clk;

    int unsigned xbins[256];
    int unsigned ybins[256];
    int          lat_x = 1;
    int          lat_y = 1;
    int          checks = 0;
    int          errors = 0;

    int e_xpk, e_xpc, e_xmn, e_xmx, e_ypk, e_ypc, e_ymn, e_ymx, e_sum;
    bit e_xocc, e_yocc;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Store model: a request seen in cycle k is answered in cycle k+lat on each axis.
    bit req_v[16];
    int req_i[16];
    initial begin
        bit cap_v;
        int cap_i;
        for (int j = 0; j < 16; j++) begin req_v[j] = 1'b0; req_i[j] = 0; end
        hist.xValid = 1'b0; hist.yValid = 1'b0;
        hist.xHistogramOut = 9'd0; hist.yHistogramOut = 9'd0;
        forever begin
            @(negedge clk);
            cap_v = hist.readHistogram;
            cap_i = int'(hist.histIndex);
            @(posedge clk);
            #1;
            for (int j = 15; j > 0; j--) begin req_v[j] = req_v[j-1]; req_i[j] = req_i[j-1]; end
            req_v[0] = cap_v && reset;
            req_i[0] = cap_i;
            if (!reset) for (int j = 0; j < 16; j++) req_v[j] = 1'b0;
            hist.xValid        = req_v[lat_x-1];
            hist.yValid        = req_v[lat_y-1];
            hist.xHistogramOut = req_v[lat_x-1] ? 9'(xbins[req_i[lat_x-1]]) : 9'($urandom);
            hist.yHistogramOut = req_v[lat_y-1] ? 9'(ybins[req_i[lat_y-1]]) : 9'($urandom);
        end
    end

    task automatic axis_model(input int unsigned b[256], input int thr,
                              output int pk, output int pc, output int mn, output int mx,
                              output bit occ);
        pc = 0;
        foreach (b[i]) if (int'(b[i]) > pc) pc = int'(b[i]);
        pk = 0;
        for (int i = 255; i >= 0; i--) if (int'(b[i]) == pc) pk = i;
        occ = 1'b0; mn = 0; mx = 0;
        for (int i = 255; i >= 0; i--) if (int'(b[i]) > thr) begin mn = i; occ = 1'b1; end
        for (int i = 0; i < 256; i++) if (int'(b[i]) > thr) mx = i;
    endtask

    task automatic model(input int thr);
        axis_model(xbins, thr, e_xpk, e_xpc, e_xmn, e_xmx, e_xocc);
        axis_model(ybins, thr, e_ypk, e_ypc, e_ymn, e_ymx, e_yocc);
        e_sum = 0;
        foreach (xbins[i]) e_sum += int'(xbins[i]);
    endtask

    task automatic fill_random(input int density);
        foreach (xbins[i]) begin
            xbins[i] = ($urandom_range(0, 99) < density) ? $urandom_range(1, 256) : 0;
            ybins[i] = ($urandom_range(0, 99) < density) ? $urandom_range(1, 256) : 0;
        end
    endtask

    task automatic run_scan(input string name, input int thr, input int lx, input int ly,
                            input bit poke);
        int n, first_done, done_cnt, exp_done;
        model(thr);
        lat_x = lx; lat_y = ly;
        exp_done = 257 + ((lx > ly) ? lx : ly);
        @(negedge clk);
        start = 1'b1;
        binThreshold = 9'(thr);
        @(negedge clk);
        start = 1'b0;
        n = 1; first_done = 0; done_cnt = 0;
        while (n < 1200 && (first_done == 0 || n < first_done + 6)) begin
            if (n == 1) begin
                check_val({name, "_rd_first"}, 32'(hist.readHistogram), 32'd1);
                check_val({name, "_idx_first"}, 32'(hist.histIndex), 32'd0);
                check_val({name, "_busy_first"}, 32'(busy), 32'd1);
            end
            if (n == 256) check_val({name, "_idx_last"}, 32'(hist.histIndex), 32'd255);
            if (n == 257) check_val({name, "_rd_off"}, 32'(hist.readHistogram), 32'd0);
            if (done) begin
                done_cnt++;
                if (first_done == 0) begin
                    first_done = n;
                    check_val({name, "_busy_at_done"}, 32'(busy), 32'd1);
                    check_val({name, "_xpeak"}, 32'(xPeak), 32'(e_xpk));
                    check_val({name, "_xpeakcnt"}, 32'(xPeakCount), 32'(e_xpc));
                    check_val({name, "_ypeak"}, 32'(yPeak), 32'(e_ypk));
                    check_val({name, "_ypeakcnt"}, 32'(yPeakCount), 32'(e_ypc));
                    check_val({name, "_xmin"}, 32'(xMin), 32'(e_xmn));
                    check_val({name, "_xmax"}, 32'(xMax), 32'(e_xmx));
                    check_val({name, "_ymin"}, 32'(yMin), 32'(e_ymn));
                    check_val({name, "_ymax"}, 32'(yMax), 32'(e_ymx));
                    check_val({name, "_total"}, 32'(pixelTotal), 32'(e_sum));
                    check_val({name, "_found"}, 32'(objectFound), 32'(e_xocc && e_yocc));
                end
            end
            if (first_done != 0 && n == first_done + 1)
                check_val({name, "_busy_after"}, 32'(busy), 32'd0);
            if (poke && n == 50) binThreshold = 9'($urandom);
            start = (poke && (n == 100 || n == 200 || n == exp_done)) ? 1'b1 : 1'b0;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check_val({name, "_done_cycle"}, 32'(first_done), 32'(exp_done));
        check_val({name, "_done_count"}, 32'(done_cnt), 32'd1);
        check_val({name, "_total_hold"}, 32'(pixelTotal), 32'(e_sum));
    endtask

    initial begin
        int dones;
        reset = 1'b1;
        start = 1'b0;
        binThreshold = 9'd0;
        foreach (xbins[i]) begin xbins[i] = 0; ybins[i] = 0; end
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_state", {15'd0, hist.readHistogram, hist.histIndex, busy, done, objectFound,
                  5'd0} | 32'(xPeak | yPeak | xMin | xMax | yMin | yMax) |
                  32'(xPeakCount | yPeakCount) | 32'(pixelTotal), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Single spike per axis
        xbins[100] = 40; ybins[57] = 30;
        run_scan("spike", 0, 1, 1, 1'b0);

        // Flat run with ties, above and at threshold
        foreach (xbins[i]) begin xbins[i] = 0; ybins[i] = 0; end
        for (int i = 10; i <= 20; i++) begin xbins[i] = 5; ybins[i] = 5; end
        run_scan("flat_t4", 4, 1, 1, 1'b0);
        run_scan("flat_t5", 5, 1, 1, 1'b0);

        // Fully saturated frame
        foreach (xbins[i]) begin xbins[i] = 256; ybins[i] = 256; end
        run_scan("full", 0, 1, 1, 1'b0);

        // Skewed Y latency, extra starts and threshold wiggle during the scan
        fill_random(20);
        run_scan("skew_poke", $urandom_range(0, 120), 1, 3, 1'b1);

        // Reset in the middle of a scan
        fill_random(30);
        lat_x = 1; lat_y = 1;
        @(negedge clk); start = 1'b1; binThreshold = 9'd10;
        @(negedge clk); start = 1'b0;
        repeat (119) @(negedge clk);
        reset = 1'b0;
        #1;
        check_val("midreset_outputs", 32'(hist.readHistogram) | 32'(hist.histIndex) | 32'(busy) |
                  32'(done) | 32'(objectFound) | 32'(xPeak | yPeak | xMin | xMax | yMin | yMax) |
                  32'(xPeakCount | yPeakCount) | 32'(pixelTotal), 32'd0);
        dones = 0;
        repeat (3) begin @(negedge clk); if (done) dones++; end
        reset = 1'b1;
        repeat (200) begin @(negedge clk); if (done || busy) dones++; end
        check_val("midreset_no_done", 32'(dones), 32'd0);
        run_scan("after_reset", 10, 1, 1, 1'b0);

        // Back-to-back scans with fresh data and timing
        for (int k = 0; k < 4; k++) begin
            fill_random((k == 3) ? 0 : $urandom_range(1, 40));
            run_scan($sformatf("b2b%0d", k), $urandom_range(0, 200),
                     $urandom_range(1, 5), $urandom_range(1, 5), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
